// File: rtl/mem_prio_arbiter.sv
// N-master memory arbiter: privileged master, round-robin among the rest,
// starvation override, and an in-order tag FIFO routing upstream responses back.
module mem_prio_arbiter #(
    parameter int unsigned CNT          = 2,
    parameter int unsigned QUEUE_DEPTH  = 2,
    parameter int unsigned PRIO_MASTER  = 1,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned PIPE         = 1,
    parameter int unsigned REQ_W        = 32,
    parameter int unsigned RESP_W       = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CNT-1:0]                  master_req_valid_i,
    input  logic [CNT-1:0][REQ_W-1:0]       master_req_data_i,
    output logic [CNT-1:0]                  master_req_ready_o,
    output logic [CNT-1:0]                  master_resp_valid_o,
    output logic [CNT-1:0][RESP_W-1:0]      master_resp_data_o,
    input  logic [CNT-1:0]                  master_resp_ready_i,
    output logic                            slave_req_valid_o,
    output logic [REQ_W-1:0]                slave_req_data_o,
    input  logic                            slave_req_ready_i,
    input  logic                            slave_resp_valid_i,
    input  logic [RESP_W-1:0]               slave_resp_data_i,
    output logic                            slave_resp_ready_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] inflight
);

    localparam int unsigned IDX_W    = (CNT > 1) ? $clog2(CNT) : 1;
    localparam int unsigned PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned OCC_W    = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned SC_W     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam bit          HAS_PRIO = (PRIO_MASTER < CNT);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [OCC_W-1:0] occ_t;
    typedef logic [SC_W-1:0]  sc_t;

    localparam idx_t PRIO_IDX = idx_t'(HAS_PRIO ? PRIO_MASTER : 0);
    localparam idx_t LAST_IDX = idx_t'(CNT - 1);
    localparam ptr_t LAST_PTR = ptr_t'(QUEUE_DEPTH - 1);
    localparam occ_t FULL_OCC = occ_t'(QUEUE_DEPTH);

    typedef enum logic {
        ARB_FREE,
        ARB_HELD
    } arb_state_e;

    arb_state_e state_q, state_d;
    idx_t       lock_idx_q, lock_idx_d;
    idx_t       rr_ptr_q, rr_ptr_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    occ_t       occ_q, occ_d;
    logic [QUEUE_DEPTH-1:0][IDX_W-1:0] tag_q, tag_d;
    logic [CNT-1:0][SC_W-1:0]          starve_cnt_q, starve_cnt_d;

    logic empty, full, any_valid, can_push, push, pop, resp_ready;
    logic starve_hit, rr_hit;
    idx_t starve_idx, rr_idx, grant, head;

    assign empty      = (occ_q == '0);
    assign full       = (occ_q == FULL_OCC);
    assign head       = tag_q[rd_ptr_q];
    assign any_valid  = |master_req_valid_i;
    assign resp_ready = !empty && master_resp_ready_i[head];
    assign pop        = rst && slave_resp_valid_i && resp_ready;
    assign can_push   = !full || ((PIPE != 0) && pop);
    assign push       = slave_req_valid_o && slave_req_ready_i;

    always_comb begin
        starve_hit = 1'b0;
        starve_idx = '0;
        if (STARVE_LIMIT != 0) begin
            for (int unsigned i = 0; i < CNT; i++) begin
                if (!starve_hit && !(HAS_PRIO && i == PRIO_MASTER) &&
                    master_req_valid_i[idx_t'(i)] &&
                    (32'(starve_cnt_q[idx_t'(i)]) >= STARVE_LIMIT)) begin
                    starve_hit = 1'b1;
                    starve_idx = idx_t'(i);
                end
            end
        end

        rr_hit = 1'b0;
        rr_idx = '0;
        for (int unsigned k = 0; k < CNT; k++) begin
            if (!rr_hit && master_req_valid_i[idx_t'((32'(rr_ptr_q) + k) % CNT)]) begin
                rr_hit = 1'b1;
                rr_idx = idx_t'((32'(rr_ptr_q) + k) % CNT);
            end
        end

        // A held grant is honoured only while its master still presents valid,
        // so a withdrawn request can never steer another master's data upstream.
        if (state_q == ARB_HELD && master_req_valid_i[lock_idx_q]) begin
            grant = lock_idx_q;
        end else if (starve_hit) begin
            grant = starve_idx;
        end else if (HAS_PRIO && master_req_valid_i[PRIO_IDX]) begin
            grant = PRIO_IDX;
        end else begin
            grant = rr_idx;
        end
    end

    always_comb begin
        slave_req_valid_o  = rst && any_valid && can_push;
        slave_req_data_o   = master_req_data_i[grant];
        master_req_ready_o = '0;
        if (slave_req_valid_o && slave_req_ready_i) begin
            master_req_ready_o[grant] = 1'b1;
        end

        master_resp_valid_o = '0;
        if (rst && slave_resp_valid_i && !empty) begin
            master_resp_valid_o[head] = 1'b1;
        end
        for (int unsigned i = 0; i < CNT; i++) begin
            master_resp_data_o[idx_t'(i)] = slave_resp_data_i;
        end
        slave_resp_ready_o = rst && resp_ready;
        inflight           = occ_q;
    end

    always_comb begin
        state_d    = ARB_FREE;
        lock_idx_d = lock_idx_q;
        if (slave_req_valid_o && !slave_req_ready_i) begin
            state_d    = ARB_HELD;
            lock_idx_d = grant;
        end
    end

    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            tag_d[wr_ptr_q] = grant;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ptr_t'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + occ_t'(1);
            2'b01:   occ_d = occ_q - occ_t'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        if (push && !(HAS_PRIO && grant == PRIO_IDX)) begin
            rr_ptr_d = (grant == LAST_IDX) ? '0 : grant + idx_t'(1);
        end
        if (push && STARVE_LIMIT != 0) begin
            for (int unsigned i = 0; i < CNT; i++) begin
                if (grant == idx_t'(i)) begin
                    starve_cnt_d[idx_t'(i)] = '0;
                end else if (!(HAS_PRIO && i == PRIO_MASTER) &&
                             master_req_valid_i[idx_t'(i)] &&
                             (32'(starve_cnt_q[idx_t'(i)]) < STARVE_LIMIT)) begin
                    starve_cnt_d[idx_t'(i)] = starve_cnt_q[idx_t'(i)] + sc_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_FREE;
            lock_idx_q   <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            tag_q        <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            lock_idx_q   <= lock_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            tag_q        <= tag_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
